// File: rtl/input_ctrl_if.sv
// Handshake bundle between input_ctrl and its neighbours.
//   slave  : view taken by input_ctrl (UART byte in, buffer write/read, CPU read)
//   master : view taken by the UART receiver / buffer / CPU side
// Signals:
//   rx_valid, rx_data        received byte strobe and byte
//   buf_wd, buf_we           word and write strobe to the input buffer
//   buf_req                  buffer read request
//   buf_data, buf_ready      buffer read data and its valid pulse
//   cpu_rd                   CPU read request, held until cpu_valid
//   cpu_data, cpu_valid      word returned to the CPU and its valid pulse
//   cpu_stall                CPU read pending and not yet answered
//   words_avail              words written but not yet read
//   overflow                 sticky: a word was dropped on a full buffer
interface input_ctrl_if #(
  parameter int unsigned CW = 9
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [31:0]   buf_wd;
  logic          buf_we;
  logic          buf_req;
  logic [31:0]   buf_data;
  logic          buf_ready;
  logic          cpu_rd;
  logic [31:0]   cpu_data;
  logic          cpu_valid;
  logic          cpu_stall;
  logic [CW-1:0] words_avail;
  logic          overflow;

  modport slave (
    input  rx_valid, rx_data, buf_data, buf_ready, cpu_rd,
    output buf_wd, buf_we, buf_req, cpu_data, cpu_valid, cpu_stall,
           words_avail, overflow
  );

  modport master (
    output rx_valid, rx_data, buf_data, buf_ready, cpu_rd,
    input  buf_wd, buf_we, buf_req, cpu_data, cpu_valid, cpu_stall,
           words_avail, overflow
  );
endinterface

// File: rtl/input_ctrl.sv
// UART-side controller for the program input buffer.
// Packs received bytes little-endian into 32-bit words and writes them to the
// buffer, sequences CPU reads onto the buffer req/ready handshake, tracks
// occupancy so CPU reads stall while the buffer is empty, and flags overflow.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  input_ctrl_if.slave: byte input, buffer write/read, CPU read side
module input_ctrl #(
  parameter int unsigned DEPTH = 501,
  parameter int unsigned CW    = 9
) (
  input  logic         clk,
  input  logic         rst,
  input_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    phase;
  logic [23:0]   shreg;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] avail;
  logic [31:0]   buf_wd;
  logic          buf_we;
  logic [31:0]   cpu_data;
  logic          cpu_valid;
  logic          overflow;

  logic          rd_done_c;
  logic          full_c;
  logic [31:0]   word_c;

  // A read completes only when ready is seen while waiting for it.
  assign rd_done_c = (state == WAIT) && bus.buf_ready;
  // Slots are never reused, so fullness is set by the lifetime write count.
  assign full_c    = (wr_count >= CW'(DEPTH));
  assign word_c    = {bus.rx_data, shreg};

  // Byte packing and word write.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= 2'd0;
      shreg    <= 24'd0;
      wr_count <= '0;
      buf_wd   <= 32'd0;
      buf_we   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      buf_we <= 1'b0;
      if (bus.rx_valid) begin
        phase <= phase + 2'd1;
        case (phase)
          2'd0: shreg[7:0]   <= bus.rx_data;
          2'd1: shreg[15:8]  <= bus.rx_data;
          2'd2: shreg[23:16] <= bus.rx_data;
          default: begin
            if (!full_c) begin
              buf_wd   <= word_c;
              buf_we   <= 1'b1;
              wr_count <= wr_count + CW'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Occupancy: +1 on each buffer write, -1 on each completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      avail <= '0;
    end else begin
      case ({buf_we, rd_done_c})
        2'b10:   avail <= avail + CW'(1);
        2'b01:   avail <= avail - CW'(1);
        default: avail <= avail;
      endcase
    end
  end

  // Read sequencer; GAP gives the buffer a cycle to advance its read index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cpu_data  <= 32'd0;
      cpu_valid <= 1'b0;
    end else begin
      cpu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_rd && (avail != '0)) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.buf_ready) begin
            cpu_data  <= bus.buf_data;
            cpu_valid <= 1'b1;
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request drops as soon as ready is seen so the buffer delivers one word.
  assign bus.buf_req     = (state == WAIT) && !bus.buf_ready;
  assign bus.cpu_stall   = bus.cpu_rd && !cpu_valid;
  assign bus.buf_wd      = buf_wd;
  assign bus.buf_we      = buf_we;
  assign bus.cpu_data    = cpu_data;
  assign bus.cpu_valid   = cpu_valid;
  assign bus.words_avail = avail;
  assign bus.overflow    = overflow;

endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl with a small behavioural input-buffer model.
module tb_input_ctrl;
  localparam int unsigned DEPTH = 501;
  localparam int unsigned CW    = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_ctrl_if #(.CW(CW)) bus ();

  input_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural buffer: ready one cycle after req, index advances on ready.
  logic [31:0] mem [DEPTH];
  int          wr_idx;
  int          rd_idx;
  logic        rdy_q;
  logic        inj;
  logic [31:0] rd_q;

  always @(posedge clk) begin
    if (rst) begin
      wr_idx <= 0;
      rd_idx <= 0;
      rdy_q  <= 1'b0;
      rd_q   <= 32'd0;
    end else begin
      if (bus.buf_we && wr_idx < int'(DEPTH)) begin
        mem[wr_idx] <= bus.buf_wd;
        wr_idx      <= wr_idx + 1;
      end
      rdy_q <= bus.buf_req;
      rd_q  <= (rd_idx < int'(DEPTH)) ? mem[rd_idx] : 32'd0;
      if (rdy_q) rd_idx <= rd_idx + 1;
    end
  end

  assign bus.buf_ready = rdy_q | inj;
  assign bus.buf_data  = rd_q;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  // Returns the word and the number of cycles until cpu_valid (20 on timeout).
  task automatic cpu_read(output logic [31:0] d, output int lat);
    bus.cpu_rd = 1'b1;
    lat = 0;
    d   = 32'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (bus.cpu_valid) break;
    end
    d = bus.cpu_data;
    bus.cpu_rd = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    int          bad;
    int          nv;
    int          nwe;
    int          vcyc [3];
    logic [31:0] vd [3];

    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.cpu_rd   = 1'b0;
    inj          = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_buf_we",   32'(bus.buf_we), 32'd0);
    check("rst_buf_wd",   bus.buf_wd, 32'd0);
    check("rst_buf_req",  32'(bus.buf_req), 32'd0);
    check("rst_cpu_data", bus.cpu_data, 32'd0);
    check("rst_cpu_vld",  32'(bus.cpu_valid), 32'd0);
    check("rst_stall",    32'(bus.cpu_stall), 32'd0);
    check("rst_avail",    32'(bus.words_avail), 32'd0);
    check("rst_ovf",      32'(bus.overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Little-endian packing
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    check("pack_we",     32'(bus.buf_we), 32'd1);
    check("pack_wd",     bus.buf_wd, 32'h1234_5678);
    check("pack_avail0", 32'(bus.words_avail), 32'd0);
    tick();
    check("pack_avail1", 32'(bus.words_avail), 32'd1);
    check("pack_we_off", 32'(bus.buf_we), 32'd0);
    cpu_read(d, lat);
    check("rd1_data", d, 32'h1234_5678);
    check("rd1_lat",  32'(lat), 32'd3);
    check("rd1_stall_at_valid", 32'(bus.cpu_stall), 32'd0);
    check("rd1_avail", 32'(bus.words_avail), 32'd0);

    // Read held against an empty buffer
    bus.cpu_rd = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.cpu_stall || bus.cpu_valid || bus.buf_req) bad++;
    end
    check("empty_stall_cycles", 32'(bad), 32'd0);
    send_word(32'hDDCC_BBAA);
    check("empty_stall_after", 32'(bus.cpu_stall), 32'd1);
    check("empty_avail0", 32'(bus.words_avail), 32'd0);
    tick();
    check("empty_avail1", 32'(bus.words_avail), 32'd1);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (bus.cpu_valid) break;
    end
    check("empty_lat",  32'(lat), 32'd3);
    check("empty_data", bus.cpu_data, 32'hDDCC_BBAA);
    bus.cpu_rd = 1'b0;
    tick();

    // Three words, back-to-back reads
    send_word(32'hA3A2_A1A0);
    send_word(32'hB3B2_B1B0);
    send_word(32'hC3C2_C1C0);
    tick();
    check("b2b_avail3", 32'(bus.words_avail), 32'd3);
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      vcyc[i] = 0;
      vd[i]   = 32'd0;
    end
    bus.cpu_rd = 1'b1;
    for (int c = 0; c < 40 && nv < 3; c++) begin
      tick();
      if (bus.cpu_valid) begin
        vcyc[nv] = c;
        vd[nv]   = bus.cpu_data;
        nv++;
      end
    end
    bus.cpu_rd = 1'b0;
    check("b2b_count", 32'(nv), 32'd3);
    check("b2b_d0", vd[0], 32'hA3A2_A1A0);
    check("b2b_d1", vd[1], 32'hB3B2_B1B0);
    check("b2b_d2", vd[2], 32'hC3C2_C1C0);
    check("b2b_first", 32'(vcyc[0]), 32'd2);
    check("b2b_gap01", 32'(vcyc[1] - vcyc[0]), 32'd4);
    check("b2b_gap12", 32'(vcyc[2] - vcyc[1]), 32'd4);
    check("b2b_avail0", 32'(bus.words_avail), 32'd0);
    tick();

    // Stray ready outside WAIT
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("stray_avail", 32'(bus.words_avail), 32'd0);
    check("stray_valid", 32'(bus.cpu_valid), 32'd0);
    tick();
    check("stray_avail2", 32'(bus.words_avail), 32'd0);

    // Buffer write coinciding with read completion
    send_word(32'h0BAD_F00D);
    tick();
    check("coin_avail_pre", 32'(bus.words_avail), 32'd1);
    send_byte(8'h21);
    send_byte(8'h43);
    send_byte(8'h65);
    bus.cpu_rd = 1'b1;
    tick();
    check("coin_req", 32'(bus.buf_req), 32'd1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h87;
    tick();
    bus.rx_valid = 1'b0;
    check("coin_we",      32'(bus.buf_we), 32'd1);
    check("coin_wd",      bus.buf_wd, 32'h8765_4321);
    check("coin_ready",   32'(bus.buf_ready), 32'd1);
    check("coin_req_off", 32'(bus.buf_req), 32'd0);
    tick();
    check("coin_avail",   32'(bus.words_avail), 32'd1);
    check("coin_valid",   32'(bus.cpu_valid), 32'd1);
    check("coin_data",    bus.cpu_data, 32'h0BAD_F00D);
    check("coin_gap_req", 32'(bus.buf_req), 32'd0);
    bus.cpu_rd = 1'b0;
    tick();
    check("coin_idle_req", 32'(bus.buf_req), 32'd0);

    // Reset with a partial word and a read in flight
    send_byte(8'h01);
    send_byte(8'h02);
    bus.cpu_rd = 1'b1;
    tick();
    check("mid_req", 32'(bus.buf_req), 32'd1);
    rst          = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h99;
    bus.cpu_rd   = 1'b0;
    tick();
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    check("mid_req_off", 32'(bus.buf_req), 32'd0);
    check("mid_avail",   32'(bus.words_avail), 32'd0);
    check("mid_wd",      bus.buf_wd, 32'd0);
    tick();
    check("mid_valid",   32'(bus.cpu_valid), 32'd0);
    send_word(32'hDEAD_BEEF);
    check("mid_we", 32'(bus.buf_we), 32'd1);
    check("mid_wd_clean", bus.buf_wd, 32'hDEAD_BEEF);

    // Fill to capacity, then one word too many
    nwe = 1;
    for (int i = 1; i < int'(DEPTH); i++) begin
      send_word(32'(i) ^ 32'hA500_0000);
      if (bus.buf_we) nwe++;
    end
    check("fill_we_count", 32'(nwe), 32'(DEPTH));
    check("fill_ovf0", 32'(bus.overflow), 32'd0);
    tick();
    check("fill_avail", 32'(bus.words_avail), 32'(DEPTH));
    send_word(32'hFFFF_FFFF);
    check("ovf_no_we", 32'(bus.buf_we), 32'd0);
    check("ovf_set",   32'(bus.overflow), 32'd1);
    tick();
    check("ovf_avail", 32'(bus.words_avail), 32'(DEPTH));
    cpu_read(d, lat);
    check("ovf_rd_data", d, 32'hDEAD_BEEF);
    check("ovf_rd_lat",  32'(lat), 32'd3);
    check("ovf_sticky",  32'(bus.overflow), 32'd1);
    check("ovf_avail2",  32'(bus.words_avail), 32'(DEPTH - 1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/input_ctrl.md
# input_ctrl

UART-side controller for the program input buffer. Packs received bytes into 32-bit words and writes them into the buffer. Sequences CPU read requests into the buffer's `req`/`input_data_ready` handshake. Tracks occupancy so CPU reads stall cleanly while the buffer is empty, and flags overflow.

## Interface
Parameters:
- `DEPTH`, 501: buffer capacity in words. Must equal the buffer RAM depth.
- `CW`, 9: width of the word counters. Requires 2^CW > DEPTH.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high. The buffer's reset is driven from the same source, inverted.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `buf_wd`  out  32  word to buffer.
- `buf_we`  out  1  buffer write strobe, one cycle per word.
- `buf_req`  out  1  buffer read request.
- `buf_data`  in  32  buffer read data.
- `buf_ready`  in  1  buffer read-data-valid pulse.
- `cpu_rd`  in  1  CPU read request, held high until `cpu_valid`.
- `cpu_data`  out  32  word returned to CPU.
- `cpu_valid`  out  1  one-cycle pulse: `cpu_data` valid.
- `cpu_stall`  out  1  combinational: `cpu_rd & ~cpu_valid`.
- `words_avail`  out  CW  words written but not yet read.
- `overflow`  out  1  sticky: a word was dropped because the buffer was full.

## Operation
- Reset values: all outputs 0; byte phase 0; shift register 0; write count 0; FSM in IDLE.
- Byte packing, little-endian:
  - Byte k of a word (k = 0..3) lands in bits [8k+7:8k].
  - The phase counter advances on every `rx_valid` and wraps from 3 to 0.
- Word write, on the 4th byte:
  - If `words_written < DEPTH`: register `buf_wd` = assembled word, pulse `buf_we` for one cycle, increment the write count.
  - If full: drop the word, set `overflow`, do not pulse `buf_we`.
- Occupancy:
  - `words_avail` increments in the same cycle `buf_we` is asserted.
  - It decrements in the cycle `buf_ready` is seen.
  - Both events in one cycle leave it unchanged.
  - The total write count never decrements: the buffer does not reuse slots.
- Read FSM:
  - IDLE: if `cpu_rd` and `words_avail` != 0, go to WAIT. Otherwise stay; `cpu_stall` remains high while `cpu_rd` is held.
  - WAIT: `buf_req` = `~buf_ready`. On `buf_ready`: latch `buf_data` into `cpu_data`, pulse `cpu_valid` next cycle, go to GAP.
  - GAP: one cycle, `buf_req` low, so the buffer advances its read index before any new request. Then go to IDLE.
  - `buf_req` is never asserted outside WAIT.
- `cpu_data` holds its value until the next `cpu_valid`.
- Reset mid-operation:
  - A partial word is discarded and the phase returns to 0.
  - An in-flight read is abandoned and the FSM returns to IDLE.
  - `rx_valid` in the reset cycle is ignored.

## Timing
- Write path: 4th `rx_valid` at cycle T, then `buf_we` and `buf_wd` at T+1, then `words_avail` updated at T+2.
- Read path with `words_avail` > 0, `cpu_rd` first sampled at cycle R:
  - R+1: WAIT, `buf_req` = 1.
  - R+2: `buf_ready` = 1, `buf_req` = 0.
  - R+3: `cpu_valid` = 1, GAP.
  - R+4: IDLE.
  - Minimum spacing between reads: 4 cycles.
- Empty start: the first read can begin one cycle after `words_avail` becomes nonzero.
- `buf_ready` arriving outside WAIT is ignored, with no occupancy change.
- The FSM never times out. It waits in WAIT indefinitely.
- `overflow` is cleared only by `rst`.

## Test plan
- Bytes 0x78, 0x56, 0x34, 0x12 -> one `buf_we` with `buf_wd` = 0x12345678; `words_avail` = 1.
- Hold `cpu_rd` with the buffer empty for 10 cycles, then send 4 bytes -> `cpu_stall` high throughout; `cpu_valid` arrives 3 cycles after `words_avail` = 1, with the correct word.
- Write 3 words, issue 3 back-to-back reads -> `cpu_data` in write order; `cpu_valid` pulses spaced 4 cycles apart; `words_avail` ends at 0.
- Write 501 words, then 4 more bytes -> no 502nd `buf_we`; `overflow` = 1; `words_avail` = 501.
- Send 2 bytes, assert `rst`, then send 0xEF, 0xBE, 0xAD, 0xDE -> `buf_wd` = 0xDEADBEEF; no stale bytes in the word.
- 4th byte arrives in the same cycle `buf_ready` is seen during a read -> `words_avail` unchanged that cycle; no `buf_req` during GAP.
